ula_seq_driver: RTL and testbench

//   Sequencing master for the 16-bit Ula: takes operation commands over a valid/ready

---
 rtl/ula_seq_driver_if.sv | 28 ++
 rtl/ula_seq_driver.sv | 153 +++++++++++++++
 tb/tb_ula_seq_driver.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_seq_driver_if.sv
// Command/response channel bundle of ula_seq_driver.
// The block sits on the slave modport; the command producer / response consumer uses master.
interface ula_seq_driver_if #(
  parameter int WIDTH = 16
);
  // Both channels are valid/ready: a transfer happens on a rising edge where valid
  // and ready are both high; valid holds and its payload stays stable until then.
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_cout;
  logic             rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_cout, rsp_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_cout, rsp_err
  );
endinterface

// File: rtl/ula_seq_driver.sv
// Sequencing master for the combinational Ula: one command in flight, registered Ula drive.
// Define ULA_SEQ_MUL_EN to build the shift-add multiply (op 1000); otherwise op 1000 is illegal.
module ula_seq_driver #(
  parameter int WIDTH     = 16,
  parameter int MUL_STEPS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ula_seq_driver_if.slave  bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_select,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } state_t;

  if (MUL_STEPS != WIDTH) begin : g_steps_mismatch
    $error("ula_seq_driver: MUL_STEPS must equal WIDTH");
  end

  state_t           state_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_cout_q;
  logic             rsp_err_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [2:0]       alu_select_q;

`ifdef ULA_SEQ_MUL_EN
  localparam int CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lost_q;
  logic             ovf_q;
  logic             ovf_d;

  // Overflow: the adder carried out, or a multiplier bit selects a shifted
  // multiplicand that has already lost a set bit off the top.
  assign ovf_d = ovf_q | alu_cout | (mplier_q[0] & lost_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_select_q <= '0;
`ifdef ULA_SEQ_MUL_EN
      mcand_q      <= '0;
      mplier_q     <= '0;
      cnt_q        <= '0;
      lost_q       <= 1'b0;
      ovf_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!cmd_ready_q) begin
            cmd_ready_q <= 1'b1;
          end else if (bus.cmd_valid) begin
            cmd_ready_q <= 1'b0;
            if (!bus.cmd_op[3]) begin
              alu_a_q      <= bus.cmd_a;
              alu_b_q      <= bus.cmd_b;
              alu_select_q <= bus.cmd_op[2:0];
              state_q      <= EXEC;
`ifdef ULA_SEQ_MUL_EN
            end else if (bus.cmd_op == 4'b1000) begin
              alu_a_q      <= '0;
              alu_b_q      <= bus.cmd_b[0] ? bus.cmd_a : '0;
              alu_select_q <= 3'b000;
              mcand_q      <= bus.cmd_a;
              mplier_q     <= bus.cmd_b;
              cnt_q        <= '0;
              lost_q       <= 1'b0;
              ovf_q        <= 1'b0;
              state_q      <= MUL;
`endif
            end else begin
              rsp_data_q  <= '0;
              rsp_cout_q  <= 1'b0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        EXEC: begin
          rsp_data_q  <= alu_result;
          rsp_cout_q  <= alu_cout;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
`ifdef ULA_SEQ_MUL_EN
        MUL: begin
          // The Ula sum this cycle is the new accumulator; the next partial is set up alongside it.
          alu_a_q  <= alu_result;
          alu_b_q  <= mplier_q[1] ? (mcand_q << 1) : '0;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          lost_q   <= lost_q | mcand_q[WIDTH-1];
          ovf_q    <= ovf_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MUL_STEPS - 1)) begin
            rsp_data_q  <= alu_result;
            rsp_cout_q  <= ovf_d;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
`endif
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_err   = rsp_err_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_select    = alu_select_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ula_seq_driver.sv
// Directed + randomized bench for ula_seq_driver with a stand-in Ula and a product-level reference model.
// Honours ULA_SEQ_MUL_EN the same way as the design.
module tb_ula_seq_driver;

`ifdef ULA_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_select;
  logic [15:0] alu_result;
  logic        alu_cout;
  logic [1:0]  dbg_state;

  int tests_run;
  int tests_failed;

  // {err, cout, data}
  logic [17:0] exp_q[$];

  ula_seq_driver_if #(.WIDTH(16)) bus ();

  ula_seq_driver #(.WIDTH(16), .MUL_STEPS(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stand-in Ula ----------------
  function automatic logic [16:0] ula_fn(input logic [2:0] sel, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] r;
    case (sel)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {1'b0, a} - {1'b0, b};
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: r = {1'b0, ~a};
      3'd6: r = {a, 1'b0};
      default: r = {16'd0, (a < b)};
    endcase
    return r;
  endfunction

  always_comb {alu_cout, alu_result} = ula_fn(alu_select, alu_a, alu_b);

  // ---------------- reference model ----------------
  function automatic logic [17:0] ref_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] u;
    logic [31:0] p;
    if (!op[3]) begin
      u = ula_fn(op[2:0], a, b);
      return {1'b0, u[16], u[15:0]};
    end else if (op == 4'b1000 && MUL_EN) begin
      p = 32'(a) * 32'(b);
      return {1'b0, (p > 32'h0000_FFFF), p[15:0]};
    end
    return {1'b1, 1'b0, 16'h0000};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int hold, input bit early_ready);
    logic [17:0] exp;
    logic [15:0] pa, pb;
    logic [2:0]  ps;
    int          w;
    int          lat;
    exp = ref_model(op, a, b);
    exp_q.push_back(exp);
    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready_before_accept", 32'(bus.cmd_ready), 32'd1);
    pa = alu_a;
    pb = alu_b;
    ps = alu_select;
    bus.rsp_ready = early_ready;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'($urandom);
    bus.cmd_a     = 16'($urandom);
    bus.cmd_b     = 16'($urandom);
    @(negedge clk);
    check("cmd_ready_low_after_accept", 32'(bus.cmd_ready), 32'd0);
    if (!op[3]) begin
      check("alu_a_loaded", 32'(alu_a), 32'(a));
      check("alu_b_loaded", 32'(alu_b), 32'(b));
      check("alu_select_loaded", 32'(alu_select), 32'(op[2:0]));
    end else if (exp[17]) begin
      check("alu_a_held_on_err", 32'(alu_a), 32'(pa));
      check("alu_b_held_on_err", 32'(alu_b), 32'(pb));
      check("alu_select_held_on_err", 32'(alu_select), 32'(ps));
    end
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_valid_arrives", 32'(bus.rsp_valid), 32'd1);
    if (!op[3])
      check("latency_alu", 32'(lat), 32'd1);
    else if (!exp[17])
      check("latency_mul", 32'(lat), 32'd16);
    else
      check("latency_err_le1", 32'(lat <= 1), 32'd1);
    check("rsp_data", 32'(bus.rsp_data), 32'(exp[15:0]));
    check("rsp_cout", 32'(bus.rsp_cout), 32'(exp[16]));
    check("rsp_err", 32'(bus.rsp_err), 32'(exp[17]));
    if (!early_ready) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("hold_rsp_word", 32'({bus.rsp_err, bus.rsp_cout, bus.rsp_data}), 32'(exp));
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_valid_drops", 32'(bus.rsp_valid), 32'd0);
    check("cmd_ready_after_handshake", 32'(bus.cmd_ready), 32'd1);
    check("state_idle_after_handshake", 32'(dbg_state), 32'd0);
    void'(exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  op;
    logic [15:0] a, b;
    int          r;
    int          stray;
    tests_run     = 0;
    tests_failed  = 0;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'd0;
    bus.cmd_a     = 16'd0;
    bus.cmd_b     = 16'd0;
    bus.rsp_ready = 1'b0;

    // Reset held 3 cycles: every output 0
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", 32'({bus.cmd_ready, bus.rsp_valid, bus.rsp_cout, bus.rsp_err}), 32'd0);
      check("reset_data_alu", 32'({bus.rsp_data, alu_a}) | 32'({alu_b, alu_select}), 32'd0);
      check("reset_state", 32'(dbg_state), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("cmd_ready_low_at_release", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    check("cmd_ready_one_edge_after_release", 32'(bus.cmd_ready), 32'd1);

    // Add with carry out
    do_cmd(4'b0000, 16'h0001, 16'hFFFF, 0, 1'b0);
    // Back-pressure: consumer stalls 5 cycles
    do_cmd(4'b0110, 16'hA5C3, 16'h1234, 5, 1'b0);
    // Illegal opcode
    do_cmd(4'b1011, 16'h1111, 16'h2222, 2, 1'b0);
    // Multiply (or illegal when the multiply is not built)
    do_cmd(4'b1000, 16'd300, 16'd200, 1, 1'b0);
    do_cmd(4'b1000, 16'h0100, 16'h0100, 0, 1'b0);
    do_cmd(4'b1000, 16'hFFFF, 16'h0001, 0, 1'b0);
    do_cmd(4'b1000, 16'h0000, 16'hFFFF, 0, 1'b0);
    // rsp_ready held high from before accept
    do_cmd(4'b0001, 16'h0003, 16'h0005, 0, 1'b1);

    // Reset during multiply iteration 7: aborted, no response
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'b1000;
    bus.cmd_a     = 16'd1234;
    bus.cmd_b     = 16'd4321;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_state_idle", 32'(dbg_state), 32'd0);
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) stray++;
    end
    bus.rsp_ready = 1'b0;
    check("abort_no_response", 32'(stray), 32'd0);
    do_cmd(4'b1000, 16'd300, 16'd200, 0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      op = {1'b0, 3'($urandom_range(0, 7))};
      else if (r < 8) op = 4'b1000;
      else            op = 4'($urandom_range(9, 15));
      a = 16'($urandom);
      b = 16'($urandom);
      if (op == 4'b1000 && $urandom_range(0, 1) == 1) begin
        a = 16'($urandom_range(0, 511));
        b = 16'($urandom_range(0, 255));
      end
      do_cmd(op, a, b, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
